core2_cpu_1_oci_dct_packer: RTL and testbench
=============================================

Name: core2_cpu_1_oci_dct_packer

Overview:
- Controller for the OCI direct-control-transfer (DCT) trace buffer.
- Accepts 2-bit branch/transfer codes from the CPU trace tap and packs them into the 30-bit dct_buffer, tracking fill level in dct_count.
- Schedules emission of full or flushed packets to the trace-word sink over a valid/ready handshake.
- Sequences the test-end shutdown: final flush, then the sticky test_has_ended flag, which drives the OCI test bench inputs.

Parameters:
- CODES_PER_PKT, 15, codes that trigger an automatic emit; legal range 1..15.
- PKT_CNT_W, 16, width of the emitted-packet counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- dct_valid  input  1  code offered this cycle.
- dct_code  input  2  trace code.
- dct_ready  output  1  packer accepts code when dct_valid & dct_ready.
- flush_req  input  1  single-cycle request to emit a partial buffer.
- test_ending  input  1  level; starts shutdown sequence.
- tw_valid  output  1  packet valid to trace sink.
- tw_data  output  34  {dct_count[3:0], dct_buffer[29:0]} snapshot.
- tw_ready  input  1  sink accepts when tw_valid & tw_ready.
- dct_buffer  output  30  current packing buffer.
- dct_count  output  4  codes currently held (0..15).
- test_has_ended  output  1  sticky end flag.
- pkt_count  output  PKT_CNT_W  packets emitted since reset; wraps.

Behaviour:
- Reset (async assert, sync release): state ACCUM; dct_buffer=0, dct_count=0, tw_valid=0, tw_data=0, test_has_ended=0, pkt_count=0. dct_ready=1 once out of reset.
- States: ACCUM, EMIT, ENDED.
- dct_ready=1 only in ACCUM.
- ACCUM, accept (dct_valid & dct_ready):
  - dct_buffer <= {dct_buffer[27:0], dct_code} (newest code in bits 1:0); dct_count <= dct_count+1.
  - If the new count == CODES_PER_PKT -> EMIT, with tw_data loaded from the post-accept values in the same edge.
- ACCUM, flush_req or test_ending:
  - If the post-accept count is >0 -> EMIT with the post-accept snapshot. A code accepted in the same cycle is included in the packet.
  - If the post-accept count is 0: flush_req is ignored; test_ending goes directly to ENDED.
- EMIT:
  - tw_valid=1; tw_data held stable until accepted.
  - On tw_ready: dct_buffer<=0, dct_count<=0, pkt_count<=pkt_count+1 (modulo 2^PKT_CNT_W).
  - Next state is ENDED if test_ending was latched (shutdown pending bit set on any test_ending in ACCUM/EMIT); otherwise ACCUM.
  - tw_valid deasserts the cycle after the handshake.
  - flush_req in EMIT is ignored and not queued.
- ENDED: test_has_ended=1 (registered, asserted the cycle state becomes ENDED); dct_ready=0, tw_valid=0. Terminal until reset_n.
- Latency: code accept to count update is 1 cycle. Full or flush condition to tw_valid is 1 cycle.
- Back-to-back: after the EMIT handshake, ACCUM accepts a code on the very next cycle (one bubble per packet).
- No code is ever dropped. Back-pressure is applied solely through dct_ready.
- reset_n asserted mid-EMIT: the packet is discarded; all outputs return to reset values immediately.
- dct_count never exceeds CODES_PER_PKT.

Test Plan:
- Fifteen consecutive codes 2'b01 with tw_ready=1 -> dct_ready low on cycle 16; tw_valid one cycle with tw_data={4'hF, 30'h15555555}; pkt_count=1; buffer/count back to 0.
- Three codes 11,00,10 then flush_req -> tw_data={4'h3, 30'h00000032}; dct_ready=0 during EMIT.
- flush_req with count 0 -> no tw_valid, state stays ACCUM.
- dct_valid (code 10) and flush_req in the same cycle on count 1 (code 01) -> tw_data={4'h2, 30'h6}.
- Hold tw_ready=0 for 10 cycles in EMIT -> tw_valid and tw_data stable, dct_ready=0, then release -> single pkt_count increment.
- test_ending with count 2 -> one packet emitted, then test_has_ended=1, dct_ready=0 until reset. Then pulse reset_n low mid-EMIT in a second run -> tw_valid=0 and count=0 immediately.

Source files
------------

// File: rtl/core2_cpu_1_oci_dct_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : core2_cpu_1_oci_dct_packer_if
// Brief    : Handshake bundle for the DCT packer. It carries the trace-code
//            input channel (valid/ready) and the trace-word output channel
//            (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
interface core2_cpu_1_oci_dct_packer_if;
  logic        dct_valid;
  logic [1:0]  dct_code;
  logic        dct_ready;
  logic        tw_valid;
  logic [33:0] tw_data;
  logic        tw_ready;

  // CPU trace tap / trace sink side
  modport master (
    output dct_valid,
    output dct_code,
    input  dct_ready,
    input  tw_valid,
    input  tw_data,
    output tw_ready
  );

  // Packer side
  modport slave (
    input  dct_valid,
    input  dct_code,
    output dct_ready,
    output tw_valid,
    output tw_data,
    input  tw_ready
  );
endinterface
`default_nettype wire

// File: rtl/core2_cpu_1_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : core2_cpu_1_oci_dct_packer
// Brief    : Packs 2-bit trace codes into a 30-bit buffer. It emits full or
//            flushed packets over a valid/ready handshake. It also sequences
//            the test-end shutdown, which ends in a sticky test_has_ended flag.
// Revision : 1.0 - initial release
// ============================================================================
module core2_cpu_1_oci_dct_packer #(
  parameter int CODES_PER_PKT = 15,
  parameter int PKT_CNT_W     = 16
) (
  input  wire logic                   clk,
  input  wire logic                   reset_n,
  core2_cpu_1_oci_dct_packer_if.slave bus,
  input  wire logic                   flush_req,
  input  wire logic                   test_ending,
  output logic [29:0]                 dct_buffer,
  output logic [3:0]                  dct_count,
  output logic                        test_has_ended,
  output logic [PKT_CNT_W-1:0]        pkt_count
);

  localparam logic [3:0] c_codes_per_pkt = 4'(CODES_PER_PKT);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_EMIT  = 2'd1,
    ST_ENDED = 2'd2
  } state_t;

  state_t                r_state;
  logic [29:0]           r_buffer;
  logic [3:0]            r_count;
  logic                  r_tw_valid;
  logic [33:0]           r_tw_data;
  logic                  r_ended;
  logic                  r_end_pend;
  logic [PKT_CNT_W-1:0]  r_pkt_count;

  logic                  w_accept;
  logic [29:0]           w_buf_next;
  logic [3:0]            w_cnt_next;
  logic                  w_full;
  logic                  w_emit_req;

  // Post-accept view of the buffer. Flush and full decisions use these values,
  // so a code accepted in the same cycle lands in the packet.
  always_comb begin
    w_accept   = bus.dct_valid && (r_state == ST_ACCUM);
    w_buf_next = w_accept ? {r_buffer[27:0], bus.dct_code} : r_buffer;
    w_cnt_next = w_accept ? (r_count + 4'd1) : r_count;
    w_full     = w_accept && (w_cnt_next == c_codes_per_pkt);
    w_emit_req = w_full || ((flush_req || test_ending) && (w_cnt_next != 4'd0));
  end

  // Control FSM and datapath. It accumulates codes, holds a packet until the
  // sink takes it, then either returns to ACCUM or parks in ENDED.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_ACCUM;
      r_buffer    <= '0;
      r_count     <= '0;
      r_tw_valid  <= 1'b0;
      r_tw_data   <= '0;
      r_ended     <= 1'b0;
      r_end_pend  <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          r_buffer <= w_buf_next;
          r_count  <= w_cnt_next;
          if (test_ending) begin
            r_end_pend <= 1'b1;
          end
          if (w_emit_req) begin
            r_state    <= ST_EMIT;
            r_tw_valid <= 1'b1;
            r_tw_data  <= {w_cnt_next, w_buf_next};
          end else if (test_ending) begin
            // Nothing is buffered, so no final packet is needed.
            r_state <= ST_ENDED;
            r_ended <= 1'b1;
          end
        end
        ST_EMIT: begin
          // flush_req is deliberately ignored here; a shutdown request is remembered.
          if (test_ending) begin
            r_end_pend <= 1'b1;
          end
          if (bus.tw_ready) begin
            r_buffer    <= '0;
            r_count     <= '0;
            r_tw_valid  <= 1'b0;
            r_pkt_count <= r_pkt_count + 1'b1;
            if (r_end_pend || test_ending) begin
              r_state <= ST_ENDED;
              r_ended <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_ENDED: begin
          r_tw_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

  assign bus.dct_ready  = (r_state == ST_ACCUM);
  assign bus.tw_valid   = r_tw_valid;
  assign bus.tw_data    = r_tw_data;
  assign dct_buffer     = r_buffer;
  assign dct_count      = r_count;
  assign test_has_ended = r_ended;
  assign pkt_count      = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_core2_cpu_1_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_core2_cpu_1_oci_dct_packer
// Brief    : Directed bench for the DCT packer. The stimulus pushes the
//            expected packets into a queue. A negedge monitor compares each
//            presented packet against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core2_cpu_1_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush_req = 1'b0;
  logic        test_ending = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
  logic [15:0] pkt_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];

  core2_cpu_1_oci_dct_packer_if bus ();

  core2_cpu_1_oci_dct_packer #(
    .CODES_PER_PKT (15),
    .PKT_CNT_W     (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus.slave),
    .flush_req      (flush_req),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended),
    .pkt_count      (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] code);
    bus.dct_valid = 1'b1;
    bus.dct_code  = code;
    tick();
    bus.dct_valid = 1'b0;
  endtask

  // Scoreboard monitor: any presented packet must match the queue head, and it
  // is popped when the handshake completes on the following edge.
  always @(negedge clk) begin
    if (reset_n && bus.tw_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_packet: got %0h expected none", bus.tw_data);
      end else begin
        chk("tw_data", 64'(bus.tw_data), 64'(exp_q[0]));
        if (bus.tw_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.dct_valid = 1'b0;
    bus.dct_code  = 2'b00;
    bus.tw_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_buffer", 64'(dct_buffer), 64'd0);
    chk("rst_count", 64'(dct_count), 64'd0);
    chk("rst_tw_valid", 64'(bus.tw_valid), 64'd0);
    chk("rst_tw_data", 64'(bus.tw_data), 64'd0);
    chk("rst_ended", 64'(test_has_ended), 64'd0);
    chk("rst_pkt", 64'(pkt_count), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_ready", 64'(bus.dct_ready), 64'd1);

    // Fifteen 01 codes trigger a full packet
    exp_q.push_back({4'hF, 30'h15555555});
    for (int i = 0; i < 15; i++) send(2'b01);
    chk("full_ready_low", 64'(bus.dct_ready), 64'd0);
    chk("full_tw_valid", 64'(bus.tw_valid), 64'd1);
    tick();
    chk("full_tw_valid_drop", 64'(bus.tw_valid), 64'd0);
    chk("full_pkt", 64'(pkt_count), 64'd1);
    chk("full_count_clr", 64'(dct_count), 64'd0);
    chk("full_buf_clr", 64'(dct_buffer), 64'd0);
    chk("full_ready_back", 64'(bus.dct_ready), 64'd1);

    // A flush with three codes buffered
    exp_q.push_back({4'h3, 30'h00000032});
    send(2'b11);
    send(2'b00);
    send(2'b10);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("flush_ready_low", 64'(bus.dct_ready), 64'd0);
    chk("flush_tw_valid", 64'(bus.tw_valid), 64'd1);
    tick();
    chk("flush_pkt", 64'(pkt_count), 64'd2);

    // A flush on an empty buffer is ignored
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("empty_flush_valid", 64'(bus.tw_valid), 64'd0);
    chk("empty_flush_ready", 64'(bus.dct_ready), 64'd1);
    tick();
    chk("empty_flush_pkt", 64'(pkt_count), 64'd2);

    // A code accepted in the same cycle as the flush joins the packet
    exp_q.push_back({4'h2, 30'h6});
    send(2'b01);
    bus.dct_valid = 1'b1;
    bus.dct_code  = 2'b10;
    flush_req     = 1'b1;
    tick();
    bus.dct_valid = 1'b0;
    flush_req     = 1'b0;
    chk("same_cycle_count", 64'(dct_count), 64'd2);
    tick();
    chk("same_cycle_pkt", 64'(pkt_count), 64'd3);

    // Back-pressure: the packet stays stable and the flush is not queued
    bus.tw_ready = 1'b0;
    exp_q.push_back({4'h3, 30'h29});
    send(2'b10);
    send(2'b10);
    send(2'b01);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      chk("stall_valid", 64'(bus.tw_valid), 64'd1);
      chk("stall_ready", 64'(bus.dct_ready), 64'd0);
    end
    chk("stall_pkt_hold", 64'(pkt_count), 64'd3);
    bus.tw_ready = 1'b1;
    tick();
    chk("stall_pkt", 64'(pkt_count), 64'd4);
    tick();
    chk("stall_no_requeue", 64'(bus.tw_valid), 64'd0);

    // test_ending with two codes: final packet, then the sticky end flag
    exp_q.push_back({4'h2, 30'hD});
    send(2'b11);
    send(2'b01);
    test_ending = 1'b1;
    tick();
    chk("end_emit_valid", 64'(bus.tw_valid), 64'd1);
    chk("end_flag_early", 64'(test_has_ended), 64'd0);
    tick();
    chk("end_flag", 64'(test_has_ended), 64'd1);
    chk("end_pkt", 64'(pkt_count), 64'd5);
    test_ending = 1'b0;
    for (int i = 0; i < 3; i++) send(2'b11);
    chk("end_ready", 64'(bus.dct_ready), 64'd0);
    chk("end_valid", 64'(bus.tw_valid), 64'd0);
    chk("end_count", 64'(dct_count), 64'd0);
    chk("end_sticky", 64'(test_has_ended), 64'd1);

    // Second run: a reset mid-EMIT discards the packet immediately
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rerun_ended_clr", 64'(test_has_ended), 64'd0);
    chk("rerun_pkt_clr", 64'(pkt_count), 64'd0);
    bus.tw_ready = 1'b0;
    exp_q.push_back({4'h2, 30'h5});
    send(2'b01);
    send(2'b01);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("mid_emit_valid", 64'(bus.tw_valid), 64'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.tw_valid), 64'd0);
    chk("mid_rst_count", 64'(dct_count), 64'd0);
    chk("mid_rst_buffer", 64'(dct_buffer), 64'd0);
    void'(exp_q.pop_front());
    bus.tw_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();

    // test_ending with an empty buffer goes straight to ENDED
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    chk("empty_end_flag", 64'(test_has_ended), 64'd1);
    chk("empty_end_valid", 64'(bus.tw_valid), 64'd0);
    chk("empty_end_pkt", 64'(pkt_count), 64'd0);
    tick();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
